// File: rtl/seq_match_fsm.sv
// seq_match_fsm: streaming detector asserting a combinational match when the last
//    LEN accepted W-bit symbols equal a programmable, bit-maskable pattern.
// Ports: clk/rstn (async active-low); in_valid/in_sym symbol stream; overlap mode;
//    pat_load/pat_data/pat_mask pattern strobe; cnt_clr; match, match_cnt, armed.
module seq_match_fsm #(
   parameter int W     = 2,
   parameter int LEN   = 3,
   parameter int CNT_W = 8,
   parameter logic [LEN*W-1:0] PAT_RST  = '0,
   parameter logic [LEN*W-1:0] MASK_RST = '1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   input  logic [W-1:0]       in_sym,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [LEN*W-1:0]   pat_data,
   input  logic [LEN*W-1:0]   pat_mask,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int HW = (LEN-1)*W;
   localparam int FW = $clog2(LEN);
   localparam logic [FW-1:0] FILL_MAX = FW'(LEN-1);

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      ARMED
   } state_t;

   logic [HW-1:0]      hist_q, hist_n;
   logic [FW-1:0]      fill_q, fill_n;
   logic [LEN*W-1:0]   pat_q, pat_n;
   logic [LEN*W-1:0]   mask_q, mask_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [LEN*W-1:0]   window;
   logic               hit;
   state_t             state;

   // State register: the fill level is the state; hist/pattern/counter ride along.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PAT_RST;
         mask_q <= MASK_RST;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_n;
         fill_q <= fill_n;
         pat_q  <= pat_n;
         mask_q <= mask_n;
         cnt_q  <= cnt_n;
      end
   end

   // Next-state and Mealy output logic.
   always_comb begin
      hist_n = hist_q;
      fill_n = fill_q;
      pat_n  = pat_q;
      mask_n = mask_q;
      cnt_n  = cnt_q;

      if (fill_q == '0)
         state = EMPTY;
      else if (fill_q == FILL_MAX)
         state = ARMED;
      else
         state = FILLING;

      armed  = (state == ARMED);
      window = {hist_q, in_sym};
      hit    = ((window ^ pat_q) & mask_q) == '0;
      // A load cycle discards the presented symbol, so it can never complete a match.
      match  = in_valid & armed & ~pat_load & hit;

      if (pat_load) begin
         pat_n  = pat_data;
         mask_n = pat_mask;
         hist_n = '0;
         fill_n = '0;
      end else if (in_valid) begin
         if (match && !overlap) begin
            // Non-overlapping: the matched symbols are consumed entirely.
            hist_n = '0;
            fill_n = '0;
         end else begin
            hist_n = window[HW-1:0];
            case (state)
               ARMED:   fill_n = fill_q;
               default: fill_n = fill_q + 1'b1;
            endcase
         end
      end

      if (cnt_clr)
         cnt_n = '0;
      else if (match && (cnt_q != {CNT_W{1'b1}}))
         cnt_n = cnt_q + 1'b1;
   end

   assign match_cnt = cnt_q;

endmodule
